// File: rtl/paillier_pkg.sv
// Shared types and helpers for the Paillier encryption engine.
package paillier_pkg;

    typedef logic [3:0] enc_state_t;

    localparam enc_state_t S_IDLE    = 4'd0;
    localparam enc_state_t S_RD_REQ  = 4'd1;
    localparam enc_state_t S_RD_WAIT = 4'd2;
    localparam enc_state_t S_LATCH   = 4'd3;
    localparam enc_state_t S_SQR_N   = 4'd4;
    localparam enc_state_t S_RED_G   = 4'd5;
    localparam enc_state_t S_EXP_G   = 4'd6;
    localparam enc_state_t S_RED_R   = 4'd7;
    localparam enc_state_t S_EXP_R   = 4'd8;
    localparam enc_state_t S_COMBINE = 4'd9;
    localparam enc_state_t S_WRITE   = 4'd10;
    localparam enc_state_t S_NEXT    = 4'd11;
    localparam enc_state_t S_FIN     = 4'd12;

    // Modulus / ciphertext width for a given key width.
    function automatic int unsigned W_OF(input int unsigned data_width);
        return 2 * data_width;
    endfunction

    // Start-to-done latency of mod_mult for operand width w.
    function automatic int unsigned MM_LATENCY(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/paillier_encrypt_mod_mult.sv
// Bit-serial MSB-first interleaved modular multiplier: p = a*b mod M, needs b < M.
module mod_mult
    import paillier_pkg::*;
#(
    parameter int unsigned W = 2048
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] M,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned ITERS = MM_LATENCY(W) - 2;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  m_r;
    logic [W+1:0]  acc;
    logic [W+1:0]  t0;
    logic [W+1:0]  t1;
    logic [W+1:0]  t2;
    logic [CW-1:0] cnt;
    logic          run;

    // acc < M keeps 2*acc + b below 3*M, so two subtracts always suffice.
    always_comb begin
        t0 = (acc << 1) + (a_r[W-1] ? {2'b00, b_r} : '0);
        t1 = (t0 >= {2'b00, m_r}) ? t0 - {2'b00, m_r} : t0;
        t2 = (t1 >= {2'b00, m_r}) ? t1 - {2'b00, m_r} : t1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_r  <= '0;
            b_r  <= '0;
            m_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r <= a;
                b_r <= b;
                m_r <= M;
                acc <= '0;
                cnt <= CW'(ITERS);
                run <= 1'b1;
            end else if (run) begin
                if (cnt != '0) begin
                    acc <= t2;
                    a_r <= a_r << 1;
                    cnt <= cnt - CW'(1);
                end else begin
                    run  <= 1'b0;
                    done <= 1'b1;
                    p    <= acc[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/paillier_encrypt.sv
// Batch Paillier encryptor: c = g^m * r^n mod n^2 per record, fixed timing per record.
module paillier_encrypt
    import paillier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 1024,
    parameter int unsigned RAM_ADDR_WIDTH = 5,
    parameter int unsigned FILE_SIZE      = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [RAM_ADDR_WIDTH-1:0]      rd_addr,
    input  logic [DATA_WIDTH-1:0]          n_din,
    input  logic [DATA_WIDTH-1:0]          g_din,
    input  logic [DATA_WIDTH-1:0]          m_din,
    input  logic [DATA_WIDTH-1:0]          r_din,
    output logic [RAM_ADDR_WIDTH-1:0]      c_wr_addr,
    output logic                           c_wr_en,
    output logic [W_OF(DATA_WIDTH)-1:0]    c_dout
);

    localparam int unsigned W  = W_OF(DATA_WIDTH);
    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(FILE_SIZE - 1);

    enc_state_t                state, state_n;
    logic [RAM_ADDR_WIDTH-1:0] idx, idx_n, c_wr_addr_n;
    logic                      busy_n, done_n, err_n, c_wr_en_n;
    logic [W-1:0]              c_dout_n;
    logic [DATA_WIDTH-1:0]     n_r, n_r_n, g_r, g_r_n, m_r, m_r_n, r_r, r_r_n;
    logic [W-1:0]              nsq, nsq_n, base, base_n, acc, acc_n;
    logic [W-1:0]              accg, accg_n, sq, sq_n, mm_a, mm_a_n, mm_b, mm_b_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic                      phase, phase_n, mm_busy, mm_busy_n, mm_start, mm_start_n;
    logic                      mm_done;
    logic [W-1:0]              mm_p;
    logic                      ebit;
    logic [W-1:0]              exp_acc;

    assign rd_addr = idx;
    assign ebit    = (state == S_EXP_G) ? m_r[cnt] : n_r[cnt];
    // The multiply by base always runs; the bit only picks which result survives.
    assign exp_acc = ebit ? mm_p : sq;

    mod_mult #(.W(W)) u_mm (
        .clock (clock),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .M     (nsq),
        .done  (mm_done),
        .p     (mm_p)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            c_wr_en   <= 1'b0;
            c_wr_addr <= '0;
            c_dout    <= '0;
            n_r       <= '0;
            g_r       <= '0;
            m_r       <= '0;
            r_r       <= '0;
            nsq       <= '0;
            base      <= '0;
            acc       <= '0;
            accg      <= '0;
            sq        <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            cnt       <= '0;
            phase     <= 1'b0;
            mm_busy   <= 1'b0;
            mm_start  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            c_wr_en   <= c_wr_en_n;
            c_wr_addr <= c_wr_addr_n;
            c_dout    <= c_dout_n;
            n_r       <= n_r_n;
            g_r       <= g_r_n;
            m_r       <= m_r_n;
            r_r       <= r_r_n;
            nsq       <= nsq_n;
            base      <= base_n;
            acc       <= acc_n;
            accg      <= accg_n;
            sq        <= sq_n;
            mm_a      <= mm_a_n;
            mm_b      <= mm_b_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            mm_busy   <= mm_busy_n;
            mm_start  <= mm_start_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        busy_n      = busy;
        done_n      = done;
        err_n       = err;
        c_wr_en_n   = 1'b0;
        c_wr_addr_n = c_wr_addr;
        c_dout_n    = c_dout;
        n_r_n       = n_r;
        g_r_n       = g_r;
        m_r_n       = m_r;
        r_r_n       = r_r;
        nsq_n       = nsq;
        base_n      = base;
        acc_n       = acc;
        accg_n      = accg;
        sq_n        = sq;
        mm_a_n      = mm_a;
        mm_b_n      = mm_b;
        cnt_n       = cnt;
        phase_n     = phase;
        mm_busy_n   = mm_busy;
        mm_start_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_RD_REQ;
                end
            end
            S_RD_REQ:  state_n = S_RD_WAIT;
            S_RD_WAIT: state_n = S_LATCH;
            S_LATCH: begin
                n_r_n = n_din;
                g_r_n = g_din;
                m_r_n = m_din;
                r_r_n = r_din;
                if (n_din < DATA_WIDTH'(2)) begin
                    err_n       = 1'b1;
                    c_wr_en_n   = 1'b1;
                    c_wr_addr_n = idx;
                    c_dout_n    = '0;
                    state_n     = S_WRITE;
                end else begin
                    nsq_n   = '0;
                    cnt_n   = CW'(DATA_WIDTH - 1);
                    state_n = S_SQR_N;
                end
            end
            S_SQR_N: begin
                nsq_n = (nsq << 1) + (n_r[cnt] ? W'(n_r) : '0);
                if (cnt == '0) state_n = S_RED_G;
                else           cnt_n   = cnt - CW'(1);
            end
            S_RED_G, S_RED_R: begin
                if (!mm_busy) begin
                    mm_a_n     = W'((state == S_RED_G) ? g_r : r_r);
                    mm_b_n     = W'(1);
                    mm_start_n = 1'b1;
                    mm_busy_n  = 1'b1;
                end else if (mm_done) begin
                    mm_busy_n = 1'b0;
                    base_n    = mm_p;
                    acc_n     = W'(1);
                    cnt_n     = CW'(DATA_WIDTH - 1);
                    phase_n   = 1'b0;
                    state_n   = (state == S_RED_G) ? S_EXP_G : S_EXP_R;
                end
            end
            S_EXP_G, S_EXP_R: begin
                if (!mm_busy) begin
                    mm_a_n     = phase ? sq : acc;
                    mm_b_n     = phase ? base : acc;
                    mm_start_n = 1'b1;
                    mm_busy_n  = 1'b1;
                end else if (mm_done) begin
                    mm_busy_n = 1'b0;
                    if (!phase) begin
                        sq_n    = mm_p;
                        phase_n = 1'b1;
                    end else begin
                        acc_n   = exp_acc;
                        phase_n = 1'b0;
                        if (cnt == '0) begin
                            if (state == S_EXP_G) begin
                                accg_n  = exp_acc;
                                state_n = S_RED_R;
                            end else begin
                                state_n = S_COMBINE;
                            end
                        end else begin
                            cnt_n = cnt - CW'(1);
                        end
                    end
                end
            end
            S_COMBINE: begin
                if (!mm_busy) begin
                    mm_a_n     = accg;
                    mm_b_n     = acc;
                    mm_start_n = 1'b1;
                    mm_busy_n  = 1'b1;
                end else if (mm_done) begin
                    mm_busy_n   = 1'b0;
                    c_wr_en_n   = 1'b1;
                    c_wr_addr_n = idx;
                    c_dout_n    = mm_p;
                    state_n     = S_WRITE;
                end
            end
            // done must be visible the cycle right after the final write strobe.
            S_WRITE: begin
                if (idx == LAST_IDX) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end
                state_n = S_NEXT;
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    state_n = S_FIN;
                end else begin
                    idx_n   = idx + RAM_ADDR_WIDTH'(1);
                    state_n = S_RD_REQ;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_paillier_encrypt.sv
// Directed bench for paillier_encrypt with a plain-arithmetic Paillier model and scoreboard.
module tb_paillier_encrypt;
    import paillier_pkg::*;

    localparam int unsigned D  = 16;
    localparam int unsigned AW = 5;
    localparam int unsigned FS = 5;
    localparam int unsigned W  = W_OF(D);
    // Per record: read/latch, D squaring steps, 4D+3 multiplies each with a 2-cycle handshake, write, next.
    localparam int REC_CYC   = 3 + int'(D) + (4 * int'(D) + 3) * (int'(MM_LATENCY(W)) + 2) + 2;
    localparam int SKIP_CYC  = 5;
    localparam int BUDGET    = int'(FS) * REC_CYC + 200;

    typedef struct {
        logic [AW-1:0]   addr;
        longint unsigned data;
        longint unsigned n;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, err, c_wr_en;
    logic [AW-1:0] rd_addr, c_wr_addr;
    logic [D-1:0]  n_din, g_din, m_din, r_din;
    logic [W-1:0]  c_dout;

    logic [D-1:0]    n_mem [32];
    logic [D-1:0]    g_mem [32];
    logic [D-1:0]    m_mem [32];
    logic [D-1:0]    r_mem [32];
    longint unsigned wr_data [32];
    exp_t            exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int prev_wr = -1;
    bit chk_done = 1'b0;

    paillier_encrypt #(.DATA_WIDTH(D), .RAM_ADDR_WIDTH(AW), .FILE_SIZE(FS)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .n_din     (n_din),
        .g_din     (g_din),
        .m_din     (m_din),
        .r_din     (r_din),
        .c_wr_addr (c_wr_addr),
        .c_wr_en   (c_wr_en),
        .c_dout    (c_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        n_din <= n_mem[rd_addr];
        g_din <= g_mem[rd_addr];
        m_din <= m_mem[rd_addr];
        r_din <= r_mem[rd_addr];
    end

    function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                               longint unsigned m);
        longint unsigned res = 1 % m;
        longint unsigned bb  = b % m;
        longint unsigned ee  = e;
        while (ee != 0) begin
            if (ee[0]) res = (res * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return res;
    endfunction

    function automatic longint unsigned encrypt(longint unsigned n, longint unsigned g,
                                                longint unsigned m, longint unsigned r);
        longint unsigned nsq;
        if (n < 2) return 0;
        nsq = n * n;
        return (powmod(g, m, nsq) * powmod(r, n, nsq)) % nsq;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic set_rec(input int i, input int n, input int g, input int m, input int r);
        n_mem[i] = D'(n);
        g_mem[i] = D'(g);
        m_mem[i] = D'(m);
        r_mem[i] = D'(r);
    endtask

    task automatic run_batch();
        prev_wr = -1;
        for (int i = 0; i < 32; i++) wr_data[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < int'(FS); i++)
            exp_q.push_back('{AW'(i), encrypt(n_mem[i], g_mem[i], m_mem[i], r_mem[i]), n_mem[i]});
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared_by_start", done, 0);
        check("err_cleared_by_start", err, 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clock);
            k++;
        end
        check("done_within_budget", done, 1);
    endtask

    // Scoreboard: every write strobe is matched against the model, in order, with fixed spacing.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            prev_wr  = -1;
            chk_done = 1'b0;
        end else begin
            if (chk_done) begin
                check("done_one_cycle_after_last_write", done, 1);
                check("busy_low_after_last_write", busy, 0);
                chk_done = 1'b0;
            end
            if (c_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", c_wr_addr, 32);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", c_wr_addr, e.addr);
                    check("wr_data", c_dout, e.data);
                    check("busy_during_write", busy, 1);
                    check("done_low_during_write", done, 0);
                    if (prev_wr >= 0)
                        check("record_cycles", longint'(cyc - prev_wr),
                              (e.n < 2) ? SKIP_CYC : REC_CYC);
                    prev_wr = cyc;
                    wr_data[c_wr_addr] = c_dout;
                    if (exp_q.size() == 0) chk_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int k;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) set_rec(i, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_en", c_wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", c_wr_addr, 0);
        check("rst_dout", c_dout, 0);
        reset = 1'b1;

        check("model_gm", powmod(16, 7, 225), 106);
        check("model_rn", powmod(2, 15, 225), 143);
        check("model_c", encrypt(15, 16, 7, 2), 83);
        check("model_m0", encrypt(15, 16, 0, 2), 143);
        check("model_m0_r1", encrypt(15, 16, 0, 1), 1);

        // Batch 1: five distinct records
        set_rec(0, 15, 16, 7, 2);
        set_rec(1, 15, 16, 0, 2);
        set_rec(2, 15, 16, 0, 1);
        set_rec(3, 35, 3, 20, 11);
        set_rec(4, 221, 1234, 65535, 999);
        run_batch();
        wait_done();
        @(negedge clock);
        check("b1_err", err, 0);
        check("b1_busy", busy, 0);
        check("b1_c0", wr_data[0], 83);
        check("b1_c1", wr_data[1], 143);
        check("b1_c2", wr_data[2], 1);
        check("b1_all_written", exp_q.size(), 0);

        // Batch 2: n=1 at record 2, base >= nsq, max n, extra start pulses while busy
        set_rec(0, 15, 16, 7, 2);
        set_rec(1, 3, 100, 5, 50);
        set_rec(2, 1, 7, 7, 7);
        set_rec(3, 65535, 65535, 65535, 65535);
        set_rec(4, 2, 3, 3, 3);
        run_batch();
        repeat (100) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (2000) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("busy_ignores_start", busy, 1);
        wait_done();
        repeat (5) @(negedge clock);
        check("b2_err_sticky", err, 1);
        check("b2_c2_zero", wr_data[2], 0);
        check("b2_c0", wr_data[0], 83);

        // Batch 3: reset in the middle of record 1's r^n exponentiation
        set_rec(0, 15, 16, 7, 2);
        set_rec(1, 35, 3, 20, 11);
        set_rec(2, 15, 16, 0, 1);
        set_rec(3, 221, 1234, 65535, 999);
        set_rec(4, 15, 16, 0, 2);
        run_batch();
        k = 0;
        while (!c_wr_en && k < REC_CYC + 50) begin
            @(negedge clock);
            k++;
        end
        check("b3_first_write_seen", c_wr_en, 1);
        repeat (1744) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_wr_en", c_wr_en, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_wr_addr", c_wr_addr, 0);
        check("mid_rst_dout", c_dout, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3000) @(negedge clock);
        check("post_rst_idle", busy, 0);

        // Batch 4: reprocess from address 0 after the abort
        run_batch();
        wait_done();
        @(negedge clock);
        check("b4_err", err, 0);
        check("b4_c0", wr_data[0], 83);
        check("b4_c4", wr_data[4], 143);
        check("b4_all_written", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
